nx_ram_1r1w_hw_sched: RTL and testbench

NX_RAM_1R1W_HW_SCHED -- requirements
Module: nx_ram_1r1w_hw_sched

---
 rtl/nx_mem_typePKG_v2.sv | 4 +
 rtl/nx_rr_arb2.sv | 35 +++
 rtl/nx_ram_1r1w_hw_sched.sv | 117 +++++++++++
 tb/tb_nx_ram_1r1w_hw_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_mem_typePKG_v2.sv
// Shared memory-client constants: only the client-id width lives here.
package nx_mem_typePKG_v2;
  localparam int unsigned CLIENT_ID_W = 1;
endpackage

// File: rtl/nx_rr_arb2.sv
// 2-way round-robin arbiter; the last-grant pointer moves only when upd_i says
// the grant was actually consumed.
module nx_rr_arb2
  import nx_mem_typePKG_v2::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_i,
  input  logic                   upd_i,
  output logic [1:0]             gnt_o,
  output logic [CLIENT_ID_W-1:0] gnt_id_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_id_o = '0;
    gnt_o    = 2'b00;
    unique case (req_i)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = ~last_q;
      default: gnt_id_o = 1'b0;
    endcase
    if (|req_i) gnt_o = gnt_id_o[0] ? 2'b10 : 2'b01;
    last_d = upd_i ? gnt_id_o[0] : last_q;
  end

  // Pointer resets to client 1 so client 0 wins the first contested grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/nx_ram_1r1w_hw_sched.sv
// Schedules two read clients and two write clients onto the hw port of a 1R1W
// indirect-access RAM wrapper, yielding to software after long hw bursts.
module nx_ram_1r1w_hw_sched
  import nx_mem_typePKG_v2::*;
#(
  parameter  int N_DATA_BITS   = 32,
  parameter  int N_ENTRIES     = 1024,
  parameter  int TOTAL_LATENCY = 1,
  parameter  int MAX_HOLD      = 16,
  localparam int AW            = $clog2(N_ENTRIES),
  localparam int NCL           = 1 << CLIENT_ID_W
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCL-1:0]             rd_vld,
  input  logic [NCL*AW-1:0]          rd_addr,
  output logic [NCL-1:0]             rd_rdy,
  input  logic [NCL-1:0]             wr_vld,
  input  logic [NCL*AW-1:0]          wr_addr,
  input  logic [NCL*N_DATA_BITS-1:0] wr_dat,
  output logic [NCL-1:0]             wr_rdy,
  output logic                       rsp_vld,
  output logic [CLIENT_ID_W-1:0]     rsp_id,
  output logic [N_DATA_BITS-1:0]     rsp_dat,
  output logic                       hw_cs,
  output logic                       hw_re,
  output logic                       hw_we,
  output logic [AW-1:0]              hw_raddr,
  output logic [AW-1:0]              hw_waddr,
  output logic [N_DATA_BITS-1:0]     hw_din,
  input  logic [N_DATA_BITS-1:0]     hw_dout,
  input  logic                       hw_yield
);

  logic [NCL-1:0]         rd_gnt, wr_gnt;
  logic [CLIENT_ID_W-1:0] rd_id, wr_id;
  logic [AW-1:0]          rd_win_addr, wr_win_addr;
  logic [N_DATA_BITS-1:0] wr_win_dat;
  logic                   hazard, yield_now, rd_go, wr_go;
  logic [7:0]             hold_q, hold_d;

  logic                   vld_p_q [TOTAL_LATENCY];
  logic [CLIENT_ID_W-1:0] id_p_q  [TOTAL_LATENCY];

  nx_rr_arb2 u_rd_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (rd_vld),
    .upd_i    (rd_go),
    .gnt_o    (rd_gnt),
    .gnt_id_o (rd_id)
  );

  nx_rr_arb2 u_wr_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (wr_vld),
    .upd_i    (wr_go),
    .gnt_o    (wr_gnt),
    .gnt_id_o (wr_id)
  );

  always_comb begin
    rd_win_addr = rd_id[0] ? rd_addr[2*AW-1:AW] : rd_addr[AW-1:0];
    wr_win_addr = wr_id[0] ? wr_addr[2*AW-1:AW] : wr_addr[AW-1:0];
    wr_win_dat  = wr_id[0] ? wr_dat[2*N_DATA_BITS-1:N_DATA_BITS]
                           : wr_dat[N_DATA_BITS-1:0];

    // Write wins a same-address collision so the deferred read sees new data
    hazard    = (|rd_vld) & (|wr_vld) & (rd_win_addr == wr_win_addr);
    yield_now = (hold_q >= 8'(MAX_HOLD)) & hw_yield;

    rd_go = rst_n & (|rd_vld) & ~hazard & ~yield_now;
    wr_go = rst_n & (|wr_vld) & ~yield_now;

    rd_rdy   = rd_go ? rd_gnt : '0;
    wr_rdy   = wr_go ? wr_gnt : '0;
    hw_re    = rd_go;
    hw_we    = wr_go;
    hw_cs    = rd_go | wr_go;
    hw_raddr = rd_go ? rd_win_addr : '0;
    hw_waddr = wr_go ? wr_win_addr : '0;
    hw_din   = wr_go ? wr_win_dat  : '0;

    if (!hw_cs)               hold_d = 8'd0;
    else if (hold_q == 8'hFF) hold_d = hold_q;
    else                      hold_d = hold_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 8'd0;
    else        hold_q <= hold_d;
  end

  // Response pipe: stage 0 captures the read transfer, last stage lines up
  // with hw_dout from the wrapper
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TOTAL_LATENCY; i++) begin
        vld_p_q[i] <= 1'b0;
        id_p_q[i]  <= '0;
      end
    end else begin
      vld_p_q[0] <= rd_go;
      id_p_q[0]  <= rd_id;
      for (int i = 1; i < TOTAL_LATENCY; i++) begin
        vld_p_q[i] <= vld_p_q[i-1];
        id_p_q[i]  <= id_p_q[i-1];
      end
    end
  end

  assign rsp_vld = vld_p_q[TOTAL_LATENCY-1];
  assign rsp_id  = id_p_q[TOTAL_LATENCY-1];
  assign rsp_dat = hw_dout;

endmodule

// File: tb/tb_nx_ram_1r1w_hw_sched.sv
// Directed bench for the hw-port scheduler with a small latency-3 RAM model.
module tb_nx_ram_1r1w_hw_sched;

  localparam int DW = 32;
  localparam int NE = 16;
  localparam int TL = 3;
  localparam int MH = 4;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      rd_vld, rd_rdy, wr_vld, wr_rdy;
  logic [2*AW-1:0] rd_addr, wr_addr;
  logic [2*DW-1:0] wr_dat;
  logic            rsp_vld;
  logic [0:0]      rsp_id;
  logic [DW-1:0]   rsp_dat;
  logic            hw_cs, hw_re, hw_we, hw_yield;
  logic [AW-1:0]   hw_raddr, hw_waddr;
  logic [DW-1:0]   hw_din, hw_dout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nx_ram_1r1w_hw_sched #(
    .N_DATA_BITS   (DW),
    .N_ENTRIES     (NE),
    .TOTAL_LATENCY (TL),
    .MAX_HOLD      (MH)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_vld   (rd_vld),
    .rd_addr  (rd_addr),
    .rd_rdy   (rd_rdy),
    .wr_vld   (wr_vld),
    .wr_addr  (wr_addr),
    .wr_dat   (wr_dat),
    .wr_rdy   (wr_rdy),
    .rsp_vld  (rsp_vld),
    .rsp_id   (rsp_id),
    .rsp_dat  (rsp_dat),
    .hw_cs    (hw_cs),
    .hw_re    (hw_re),
    .hw_we    (hw_we),
    .hw_raddr (hw_raddr),
    .hw_waddr (hw_waddr),
    .hw_din   (hw_din),
    .hw_dout  (hw_dout),
    .hw_yield (hw_yield)
  );

  // RAM wrapper model: word a powers up as A000_000a, read data delayed TL cycles
  logic [DW-1:0] mem   [NE];
  logic [DW-1:0] rpipe [TL];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) mem[i] <= 32'hA000_0000 | DW'(i);
    end else if (hw_we) begin
      mem[hw_waddr] <= hw_din;
    end
    rpipe[0] <= mem[hw_raddr];
    for (int i = 1; i < TL; i++) rpipe[i] <= rpipe[i-1];
  end

  assign hw_dout = rpipe[TL-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_vld  = 2'b00;
    wr_vld  = 2'b00;
    rd_addr = '0;
    wr_addr = '0;
    wr_dat  = '0;
  endtask

  initial begin
    rst_n    = 1'b0;
    hw_yield = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Requests during reset must be ignored
    rd_vld = 2'b11;
    wr_vld = 2'b01;
    wr_addr = {4'd0, 4'd3};
    #1;
    chk("rst_rd_rdy", rd_rdy, 2'b00);
    chk("rst_wr_rdy", wr_rdy, 2'b00);
    chk("rst_hw_cs", hw_cs, 1'b0);
    chk("rst_hw_re", hw_re, 1'b0);
    chk("rst_hw_we", hw_we, 1'b0);
    chk("rst_rsp_vld", rsp_vld, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();

    // Both readers for 4 cycles: grants alternate starting at client 0
    for (int c = 0; c < 8; c++) begin
      rd_vld  = (c < 4) ? 2'b11 : 2'b00;
      rd_addr = {4'd2, 4'd1};
      #1;
      chk("rr_rd_rdy", rd_rdy, (c < 4) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
      chk("rr_hw_raddr", hw_raddr, (c < 4) ? ((c % 2 == 0) ? 1 : 2) : 0);
      if (c >= 3 && c < 7) begin
        chk("rr_rsp_vld", rsp_vld, 1'b1);
        chk("rr_rsp_id", rsp_id, ((c - 3) % 2 == 0) ? 1'b0 : 1'b1);
        chk("rr_rsp_dat", rsp_dat, ((c - 3) % 2 == 0) ? 32'hA000_0001 : 32'hA000_0002);
      end else begin
        chk("rr_rsp_idle", rsp_vld, 1'b0);
      end
      tick();
    end

    // Same-address collision: write goes, read deferred, read sees new data
    rd_vld  = 2'b01;
    rd_addr = {4'd0, 4'd5};
    wr_vld  = 2'b10;
    wr_addr = {4'd5, 4'd0};
    wr_dat  = {32'hDEAD_BEEF, 32'h0};
    #1;
    chk("haz_wr_rdy", wr_rdy, 2'b10);
    chk("haz_rd_rdy", rd_rdy, 2'b00);
    chk("haz_hw_we", hw_we, 1'b1);
    chk("haz_hw_re", hw_re, 1'b0);
    chk("haz_hw_waddr", hw_waddr, 4'd5);
    chk("haz_hw_din", hw_din, 32'hDEAD_BEEF);
    tick();
    wr_vld = 2'b00;
    wr_dat = '0;
    wr_addr = '0;
    #1;
    chk("haz_rd_rdy2", rd_rdy, 2'b01);
    chk("haz_hw_raddr2", hw_raddr, 4'd5);
    chk("haz_wr_idle_din", hw_din, 32'h0);
    tick();
    idle();
    for (int c = 2; c < 6; c++) begin
      #1;
      chk("haz_rsp_vld", rsp_vld, c == 4);
      if (c == 4) begin
        chk("haz_rsp_id", rsp_id, 1'b0);
        chk("haz_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
      end
      tick();
    end

    // Read and write granted together on different addresses
    rd_vld  = 2'b11;
    rd_addr = {4'd4, 4'd3};
    wr_vld  = 2'b11;
    wr_addr = {4'd8, 4'd7};
    wr_dat  = {32'h2222_2222, 32'h1111_1111};
    #1;
    chk("dual_rd_rdy", rd_rdy, 2'b10);
    chk("dual_wr_rdy", wr_rdy, 2'b01);
    chk("dual_hw_raddr", hw_raddr, 4'd4);
    chk("dual_hw_waddr", hw_waddr, 4'd7);
    chk("dual_hw_din", hw_din, 32'h1111_1111);
    chk("dual_hw_cs", hw_cs, 1'b1);
    tick();
    idle();
    for (int c = 1; c < 5; c++) begin
      #1;
      chk("dual_rsp_vld", rsp_vld, c == 3);
      if (c == 3) begin
        chk("dual_rsp_id", rsp_id, 1'b1);
        chk("dual_rsp_dat", rsp_dat, 32'hA000_0004);
      end
      tick();
    end

    // Yield: one gap after MAX_HOLD busy cycles when software is pending
    hw_yield = 1'b1;
    rd_vld   = 2'b01;
    rd_addr  = {4'd0, 4'd9};
    for (int c = 0; c < 7; c++) begin
      #1;
      chk("yld_hw_cs", hw_cs, c != 4);
      chk("yld_rd_rdy", rd_rdy, (c != 4) ? 2'b01 : 2'b00);
      tick();
    end
    hw_yield = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("noyld_hw_cs", hw_cs, 1'b1);
      tick();
    end
    idle();
    repeat (4) tick();

    // Latency-3 pipe with alternating clients
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        rd_vld  = (c == 1) ? 2'b01 : 2'b10;
        rd_addr = (c == 1) ? {4'd0, 4'd11} : {4'(10 + c), 4'd0};
      end else begin
        idle();
      end
      #1;
      chk("lat_rd_rdy", rd_rdy, (c == 1) ? 2'b01 : ((c < 3) ? 2'b10 : 2'b00));
      if (c >= 3 && c <= 5) begin
        chk("lat_rsp_vld", rsp_vld, 1'b1);
        chk("lat_rsp_id", rsp_id, (c == 4) ? 1'b0 : 1'b1);
        chk("lat_rsp_dat", rsp_dat, 32'hA000_0000 | 32'(c + 7));
      end else begin
        chk("lat_rsp_idle", rsp_vld, 1'b0);
      end
      tick();
    end

    // Reset right after a read transfer drops the in-flight response
    rd_vld  = 2'b01;
    rd_addr = {4'd0, 4'd6};
    #1;
    chk("mid_rd_rdy", rd_rdy, 2'b01);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hw_cs", hw_cs, 1'b0);
    chk("mid_rst_rsp_vld", rsp_vld, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("mid_rsp_flushed", rsp_vld, 1'b0);
      tick();
    end
    rd_vld  = 2'b11;
    rd_addr = {4'd2, 4'd1};
    #1;
    chk("mid_first_gnt", rd_rdy, 2'b01);
    tick();
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
